px_source_arbiter: RTL and testbench
====================================

Name: px_source_arbiter

Overview:
- Shares the single gray/sobel pixel datapath between two pixel sources: SPI receive path (src 0) and LFSR generator (src 1).
- Grants one source per cycle with round-robin arbitration and issues its pixel to the datapath as a 1-cycle strobe.
- Keeps an in-order ownership tag FIFO and routes each returned result back to the source that issued it.
- Replaces the static LFSR-enable mux in front of the gray/sobel datapath, so both sources can run concurrently.

Parameters:
- PX_BITS, 8, pixel width.
- TAG_DEPTH, 8, maximum in-flight pixels; power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  permit new grants; low requests drain.
- s0_px_i  in  PX_BITS  SPI source pixel.
- s0_valid_i  in  1  SPI source has a pixel.
- s0_ready_o  out  1  SPI pixel accepted this cycle.
- s1_px_i  in  PX_BITS  LFSR source pixel.
- s1_valid_i  in  1  LFSR source has a pixel.
- s1_ready_o  out  1  LFSR pixel accepted this cycle.
- dp_px_o  out  PX_BITS  pixel to datapath.
- dp_rdy_o  out  1  1-cycle issue strobe.
- dp_px_i  in  PX_BITS  datapath result.
- dp_rdy_i  in  1  1-cycle result strobe.
- r0_px_o  out  PX_BITS  result for SPI.
- r0_rdy_o  out  1  strobe.
- r1_px_o  out  PX_BITS  result for LFSR.
- r1_rdy_o  out  1  strobe.
- inflight_o  out  $clog2(TAG_DEPTH)+1  tags outstanding.
- idle_o  out  1  STOPPED state.
- err_o  out  1  sticky, result strobe with no outstanding tag.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0, except idle_o, which is 1.
  - Tag FIFO emptied; count 0.
  - last_grant = 1, so src 0 wins the first tie.
  - FSM goes to STOPPED.
  - Reset mid-operation discards all tags; the datapath must be reset in the same cycle.
- FSM:
  - STOPPED -> RUN when enable_i=1.
  - RUN -> DRAIN when enable_i=0 and count>0.
  - RUN -> STOPPED when enable_i=0 and count=0.
  - DRAIN -> RUN when enable_i=1.
  - DRAIN -> STOPPED when count=0 and no strobe is pending on dp_rdy_o.
  - idle_o=1 only in STOPPED.
- Grant condition:
  - state=RUN, enable_i=1, registered count<TAG_DEPTH, and at least one valid.
  - A pop in the same cycle does not free a slot until the next cycle.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both valid: grant the source not equal to last_grant.
  - last_grant updates on every grant.
- Source handshake:
  - sN_ready_o is combinational and equals grant; transfer happens when valid & ready.
  - At most one of s0_ready_o / s1_ready_o is high per cycle.
  - Sources must hold px and valid until accepted.
- Issue latency 1: the cycle after a transfer, dp_rdy_o=1 and dp_px_o = the accepted pixel. The tag (source id) is pushed in the transfer cycle.
- Back-to-back grants are allowed every cycle: up to one issue per clock.
- Datapath contract: exactly one result per issued pixel, in issue order, any latency of 1 cycle or more.
- Return with count>0:
  - dp_rdy_i pops the head tag.
  - Next cycle, the owner's rN_rdy_o=1 and rN_px_o=dp_px_i.
  - The other result strobe stays 0.
  - rN_px_o holds its value between strobes.
- Return with count=0:
  - Result dropped; err_o set and held until reset.
  - A same-cycle push does not count; the datapath cannot return in 0 cycles.
- Simultaneous push and pop: count unchanged; FIFO pointers wrap modulo TAG_DEPTH.
- Count and inflight_o:
  - inflight_o = count, which ranges 0..TAG_DEPTH.
  - Count never exceeds TAG_DEPTH.
- enable_i low: no new grants; returns keep routing normally.

Test Plan:
- Single source: only s0 valid, pixels 0x10,0x20,0x30 held valid, datapath model with 3-cycle latency echoing px+1 -> s0 accepts in 3 consecutive cycles; r0_rdy_o strobes with 0x11,0x21,0x31 in order; r1_rdy_o never high; inflight_o peaks at 3; err_o=0.
- Round-robin fairness: both valid continuously with s0=0xA0.., s1=0xB0.. -> grants alternate s0,s1,s0,s1 starting with s0 after reset; each result routed to its owner in issue order.
- Full FIFO: TAG_DEPTH=8, both sources valid, datapath never returns -> exactly 8 grants, then both ready_o=0 and inflight_o=8; one dp_rdy_i -> inflight_o=7, then exactly one further grant on the following cycle.
- Drain: 4 in flight, drop enable_i -> no new grants; idle_o stays 0 until the 4th result is routed, then idle_o=1 on the next cycle; re-raising enable_i resumes grants.
- Error and reset: dp_rdy_i pulsed with inflight_o=0 -> no rN_rdy_o strobe, err_o=1 and sticky. Assert reset_i with 5 in flight -> next cycle inflight_o=0, idle_o=1, err_o=0, all strobes 0, and the first tie after reset goes to s0.

Source files
------------

// File: rtl/px_source_arbiter.sv
// ---------------------------------------------------------------------------
// px_source_arbiter
//
// Shares one gray/sobel pixel datapath between two pixel sources (src 0 = SPI
// receive path, src 1 = LFSR generator). One source is granted per cycle by
// round-robin, its pixel is issued to the datapath as a 1-cycle strobe, and
// an in-order ownership tag FIFO routes every returned result back to the
// source that issued it.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   enable_i             permit new grants; low drains outstanding pixels
//   s0_px_i/s0_valid_i   SPI source pixel offer; s0_ready_o accepts it
//   s1_px_i/s1_valid_i   LFSR source pixel offer; s1_ready_o accepts it
//   dp_px_o/dp_rdy_o     pixel issued to the datapath (1-cycle strobe)
//   dp_px_i/dp_rdy_i     result returned by the datapath (1-cycle strobe)
//   r0_px_o/r0_rdy_o     result routed to the SPI source
//   r1_px_o/r1_rdy_o     result routed to the LFSR source
//   inflight_o           number of tags outstanding (0..TAG_DEPTH)
//   idle_o               high only while STOPPED
//   err_o                sticky: result strobe seen with no outstanding tag
//
// s0_ready_o / s1_ready_o are combinational (they equal the grant) so a
// source transfers in the same cycle it is granted; all other outputs are
// registered.
// ---------------------------------------------------------------------------
module px_source_arbiter #(
  parameter  int unsigned PX_BITS   = 8,
  parameter  int unsigned TAG_DEPTH = 8,
  localparam int unsigned CW        = $clog2(TAG_DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,

  input  logic [PX_BITS-1:0] s0_px_i,
  input  logic               s0_valid_i,
  output logic               s0_ready_o,

  input  logic [PX_BITS-1:0] s1_px_i,
  input  logic               s1_valid_i,
  output logic               s1_ready_o,

  output logic [PX_BITS-1:0] dp_px_o,
  output logic               dp_rdy_o,
  input  logic [PX_BITS-1:0] dp_px_i,
  input  logic               dp_rdy_i,

  output logic [PX_BITS-1:0] r0_px_o,
  output logic               r0_rdy_o,
  output logic [PX_BITS-1:0] r1_px_o,
  output logic               r1_rdy_o,

  output logic [CW-1:0]      inflight_o,
  output logic               idle_o,
  output logic               err_o
);

  localparam int unsigned PW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [CW-1:0]        count_q;
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [TAG_DEPTH-1:0] tag_q;        // one bit per slot: owning source id
  logic                 last_grant_q;

  logic                 can_grant_c;
  logic                 grant0_c;
  logic                 grant1_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 orphan_c;
  logic                 head_tag_c;
  logic [PX_BITS-1:0]   grant_px_c;

  // Round-robin grant; the registered count gates grants, so a same-cycle
  // pop only frees its slot on the following cycle.
  always_comb begin
    grant0_c    = 1'b0;
    grant1_c    = 1'b0;
    can_grant_c = (state_q == ST_RUN) && enable_i && !reset_i &&
                  (count_q < CW'(TAG_DEPTH));
    if (can_grant_c) begin
      if (s0_valid_i && s1_valid_i) begin
        grant0_c = last_grant_q;
        grant1_c = !last_grant_q;
      end else begin
        grant0_c = s0_valid_i;
        grant1_c = s1_valid_i;
      end
    end
  end

  assign s0_ready_o = grant0_c;
  assign s1_ready_o = grant1_c;
  assign push_c     = grant0_c | grant1_c;
  assign grant_px_c = grant1_c ? s1_px_i : s0_px_i;

  // A result only pops when a tag was outstanding before this cycle; a tag
  // pushed in the same cycle cannot be returned by a datapath of latency >= 1.
  assign pop_c      = dp_rdy_i && (count_q != '0);
  assign orphan_c   = dp_rdy_i && (count_q == '0);
  assign head_tag_c = tag_q[rd_ptr_q];

  // Run-control FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: begin
        if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_d = (count_q != '0) ? ST_DRAIN : ST_STOPPED;
        end
      end
      ST_DRAIN: begin
        // An issue strobe still on dp_rdy_o means a pixel is entering the
        // datapath, so stay until it has been accounted for.
        if (enable_i) begin
          state_d = ST_RUN;
        end else if ((count_q == '0) && !dp_rdy_o) begin
          state_d = ST_STOPPED;
        end
      end
      default: begin
        state_d = ST_STOPPED;
      end
    endcase
  end

  // State, tag FIFO and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_STOPPED;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_q        <= '0;
      last_grant_q <= 1'b1;
      dp_px_o      <= '0;
      dp_rdy_o     <= 1'b0;
      r0_px_o      <= '0;
      r0_rdy_o     <= 1'b0;
      r1_px_o      <= '0;
      r1_rdy_o     <= 1'b0;
      idle_o       <= 1'b1;
      err_o        <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_o   <= (state_d == ST_STOPPED);
      count_q  <= count_q + CW'(push_c) - CW'(pop_c);
      dp_rdy_o <= push_c;
      r0_rdy_o <= pop_c && !head_tag_c;
      r1_rdy_o <= pop_c && head_tag_c;

      if (push_c) begin
        tag_q[wr_ptr_q] <= grant1_c;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
        last_grant_q    <= grant1_c;
        dp_px_o         <= grant_px_c;
      end

      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        if (head_tag_c) begin
          r1_px_o <= dp_px_i;
        end else begin
          r0_px_o <= dp_px_i;
        end
      end

      if (orphan_c) begin
        err_o <= 1'b1;
      end
    end
  end

  assign inflight_o = count_q;

endmodule

// File: tb/tb_px_source_arbiter.sv
// ---------------------------------------------------------------------------
// tb_px_source_arbiter
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference (queue of owner tags, queue of datapath results, run/drain/stop
// mode) predicts every DUT output each cycle.
// ---------------------------------------------------------------------------
module tb_px_source_arbiter;

  localparam int PX_BITS   = 8;
  localparam int TAG_DEPTH = 8;
  localparam int CW        = $clog2(TAG_DEPTH) + 1;

  localparam int M_STOPPED = 0;
  localparam int M_RUN     = 1;
  localparam int M_DRAIN   = 2;

  logic               clk = 1'b0;
  logic               reset_i;
  logic               enable_i;
  logic [PX_BITS-1:0] s0_px_i;
  logic               s0_valid_i;
  logic               s0_ready_o;
  logic [PX_BITS-1:0] s1_px_i;
  logic               s1_valid_i;
  logic               s1_ready_o;
  logic [PX_BITS-1:0] dp_px_o;
  logic               dp_rdy_o;
  logic [PX_BITS-1:0] dp_px_i;
  logic               dp_rdy_i;
  logic [PX_BITS-1:0] r0_px_o;
  logic               r0_rdy_o;
  logic [PX_BITS-1:0] r1_px_o;
  logic               r1_rdy_o;
  logic [CW-1:0]      inflight_o;
  logic               idle_o;
  logic               err_o;

  always #5 clk = ~clk;

  px_source_arbiter #(.PX_BITS(PX_BITS), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .s0_px_i    (s0_px_i),
    .s0_valid_i (s0_valid_i),
    .s0_ready_o (s0_ready_o),
    .s1_px_i    (s1_px_i),
    .s1_valid_i (s1_valid_i),
    .s1_ready_o (s1_ready_o),
    .dp_px_o    (dp_px_o),
    .dp_rdy_o   (dp_rdy_o),
    .dp_px_i    (dp_px_i),
    .dp_rdy_i   (dp_rdy_i),
    .r0_px_o    (r0_px_o),
    .r0_rdy_o   (r0_rdy_o),
    .r1_px_o    (r1_px_o),
    .r1_rdy_o   (r1_rdy_o),
    .inflight_o (inflight_o),
    .idle_o     (idle_o),
    .err_o      (err_o)
  );

  typedef struct {
    logic [PX_BITS-1:0] px;
    int                 due;
  } dp_t;

  // Reference state
  int                 tagq[$];
  dp_t                dpq[$];
  int                 m_state;
  int                 m_last;
  logic               m_dp_rdy;
  logic [PX_BITS-1:0] m_dp_px;
  logic               m_r0_rdy;
  logic               m_r1_rdy;
  logic [PX_BITS-1:0] m_r0_px;
  logic [PX_BITS-1:0] m_r1_px;
  logic               m_err;
  logic               m_idle;

  // Environment
  logic [PX_BITS-1:0] src0_q[$];
  logic [PX_BITS-1:0] src1_q[$];
  int                 rate0 = 100;
  int                 rate1 = 100;
  int                 dp_lat = 1;
  int                 dp_budget = -1;   // -1 unlimited returns, else remaining
  bit                 force_ret = 1'b0;

  // Logs
  int                 grant_log[$];
  int                 grant_cyc[$];
  logic [PX_BITS-1:0] r0_log[$];
  logic [PX_BITS-1:0] r1_log[$];
  int                 max_inflight = 0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    tagq.delete();
    dpq.delete();
    m_state  = M_STOPPED;
    m_last   = 1;
    m_dp_rdy = 1'b0;
    m_dp_px  = '0;
    m_r0_rdy = 1'b0;
    m_r1_rdy = 1'b0;
    m_r0_px  = '0;
    m_r1_px  = '0;
    m_err    = 1'b0;
    m_idle   = 1'b1;
  endfunction

  // Sources raise valid at a random rate and hold it until accepted.
  task automatic refresh();
    if (!s0_valid_i && src0_q.size() > 0 && $urandom_range(99) < rate0) begin
      s0_valid_i = 1'b1;
      s0_px_i    = src0_q[0];
    end
    if (!s1_valid_i && src1_q.size() > 0 && $urandom_range(99) < rate1) begin
      s1_valid_i = 1'b1;
      s1_px_i    = src1_q[0];
    end
  endtask

  function automatic bit is_quiet();
    return (src0_q.size() == 0) && (src1_q.size() == 0) && !s0_valid_i &&
           !s1_valid_i && (tagq.size() == 0) && (dpq.size() == 0) && !m_dp_rdy;
  endfunction

  // One clock: drive datapath return, check grants, advance, check outputs.
  task automatic cycle();
    int                 g;
    int                 cnt;
    int                 owner;
    logic [PX_BITS-1:0] gpx;

    dp_rdy_i = 1'b0;
    if (force_ret) begin
      dp_rdy_i  = 1'b1;
      dp_px_i   = 8'h5A;
      force_ret = 1'b0;
    end else if (dp_budget != 0 && dpq.size() > 0 && dpq[0].due <= cyc) begin
      dp_rdy_i = 1'b1;
      dp_px_i  = dpq[0].px;
      dpq.delete(0);
      if (dp_budget > 0) dp_budget--;
    end
    #1;
    cnt = tagq.size();
    g   = -1;
    if (!reset_i && m_state == M_RUN && enable_i && cnt < TAG_DEPTH) begin
      if (s0_valid_i && s1_valid_i) g = (m_last == 0) ? 1 : 0;
      else if (s0_valid_i)          g = 0;
      else if (s1_valid_i)          g = 1;
    end
    check("s0_ready", 32'(s0_ready_o), 32'(g == 0));
    check("s1_ready", 32'(s1_ready_o), 32'(g == 1));
    if (s0_ready_o) begin grant_log.push_back(0); grant_cyc.push_back(cyc); end
    if (s1_ready_o) begin grant_log.push_back(1); grant_cyc.push_back(cyc); end
    gpx = (g == 1) ? s1_px_i : s0_px_i;

    @(posedge clk);
    cyc++;
    if (reset_i) begin
      m_reset();
    end else begin
      case (m_state)
        M_STOPPED: if (enable_i) m_state = M_RUN;
        M_RUN:     if (!enable_i) m_state = (cnt > 0) ? M_DRAIN : M_STOPPED;
        default: begin
          if (enable_i) m_state = M_RUN;
          else if (cnt == 0 && !m_dp_rdy) m_state = M_STOPPED;
        end
      endcase
      m_r0_rdy = 1'b0;
      m_r1_rdy = 1'b0;
      if (dp_rdy_i) begin
        if (cnt > 0) begin
          owner = tagq.pop_front();
          if (owner == 0) begin m_r0_rdy = 1'b1; m_r0_px = dp_px_i; end
          else            begin m_r1_rdy = 1'b1; m_r1_px = dp_px_i; end
        end else begin
          m_err = 1'b1;
        end
      end
      m_dp_rdy = (g >= 0);
      if (g >= 0) begin
        tagq.push_back(g);
        m_dp_px = gpx;
        m_last  = g;
        dpq.push_back('{px: gpx + 8'd1, due: cyc + dp_lat});
      end
      m_idle = (m_state == M_STOPPED);
    end

    #1;
    check("dp_rdy",   32'(dp_rdy_o),   32'(m_dp_rdy));
    check("dp_px",    32'(dp_px_o),    32'(m_dp_px));
    check("r0_rdy",   32'(r0_rdy_o),   32'(m_r0_rdy));
    check("r1_rdy",   32'(r1_rdy_o),   32'(m_r1_rdy));
    check("r0_px",    32'(r0_px_o),    32'(m_r0_px));
    check("r1_px",    32'(r1_px_o),    32'(m_r1_px));
    check("inflight", 32'(inflight_o), 32'(tagq.size()));
    check("idle",     32'(idle_o),     32'(m_idle));
    check("err",      32'(err_o),      32'(m_err));
    if (r0_rdy_o) r0_log.push_back(r0_px_o);
    if (r1_rdy_o) r1_log.push_back(r1_px_o);
    if (int'(inflight_o) > max_inflight) max_inflight = int'(inflight_o);

    if (g == 0) begin void'(src0_q.pop_front()); s0_valid_i = 1'b0; end
    if (g == 1) begin void'(src1_q.pop_front()); s1_valid_i = 1'b0; end
    refresh();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_quiet(input int limit, output bit done);
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (is_quiet()) begin done = 1'b1; break; end
      cycle();
    end
    if (!done) done = is_quiet();
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit                 done;
    int                 rcount;
    int                 last_r;
    int                 idle_cyc;
    logic [PX_BITS-1:0] exp_px;

    reset_i    = 1'b1;
    enable_i   = 1'b0;
    s0_px_i    = '0;
    s0_valid_i = 1'b0;
    s1_px_i    = '0;
    s1_valid_i = 1'b0;
    dp_px_i    = '0;
    dp_rdy_i   = 1'b0;
    m_reset();
    @(negedge clk);
    run(2);
    check("rst_idle",     32'(idle_o),     32'd1);
    check("rst_inflight", 32'(inflight_o), 32'd0);
    reset_i = 1'b0;

    // Single source, 3-cycle datapath
    enable_i = 1'b1;
    dp_lat   = 3;
    src0_q   = '{8'h10, 8'h20, 8'h30};
    refresh();
    grant_cyc.delete();
    r0_log.delete();
    r1_log.delete();
    max_inflight = 0;
    run_quiet(40, done);
    check("t1_quiet", 32'(done), 32'd1);
    check("t1_peak", 32'(max_inflight), 32'd3);
    check("t1_r0_count", 32'(r0_log.size()), 32'd3);
    check("t1_r1_count", 32'(r1_log.size()), 32'd0);
    if (grant_cyc.size() == 3) check("t1_consec", 32'(grant_cyc[2] - grant_cyc[0]), 32'd2);
    for (int i = 0; i < r0_log.size() && i < 3; i++) begin
      exp_px = 8'h11 + 8'(16 * i);
      check("t1_r0_px", 32'(r0_log[i]), 32'(exp_px));
    end
    check("t1_err", 32'(err_o), 32'd0);

    // Round-robin fairness
    pulse_reset();
    dp_lat = 2;
    for (int i = 0; i < 6; i++) begin
      src0_q.push_back(8'hA0 + 8'(i));
      src1_q.push_back(8'hB0 + 8'(i));
    end
    grant_log.delete();
    r0_log.delete();
    r1_log.delete();
    refresh();
    run_quiet(60, done);
    check("t2_quiet", 32'(done), 32'd1);
    check("t2_grants", 32'(grant_log.size()), 32'd12);
    for (int i = 0; i < grant_log.size() && i < 12; i++)
      check("t2_alternate", 32'(grant_log[i]), 32'(i % 2));
    check("t2_r0_count", 32'(r0_log.size()), 32'd6);
    check("t2_r1_count", 32'(r1_log.size()), 32'd6);
    for (int i = 0; i < r0_log.size() && i < 6; i++)
      check("t2_r0_px", 32'(r0_log[i]), 32'(8'hA1 + 8'(i)));
    for (int i = 0; i < r1_log.size() && i < 6; i++)
      check("t2_r1_px", 32'(r1_log[i]), 32'(8'hB1 + 8'(i)));

    // Full tag FIFO
    pulse_reset();
    dp_budget = 0;
    for (int i = 0; i < 12; i++) begin
      src0_q.push_back(8'(i));
      src1_q.push_back(8'h80 + 8'(i));
    end
    refresh();
    grant_log.delete();
    run(14);
    check("t3_grants", 32'(grant_log.size()), 32'd8);
    check("t3_full", 32'(inflight_o), 32'd8);
    grant_log.delete();
    dp_budget = 1;
    run(1);
    check("t3_after_pop", 32'(inflight_o), 32'd7);
    run(4);
    check("t3_one_more", 32'(grant_log.size()), 32'd1);
    check("t3_refull", 32'(inflight_o), 32'd8);
    dp_budget = -1;
    run_quiet(100, done);
    check("t3_quiet", 32'(done), 32'd1);

    // Drain
    pulse_reset();
    dp_budget = 0;
    src0_q    = '{8'h41, 8'h42, 8'h43, 8'h44};
    refresh();
    run(8);
    check("t4_inflight", 32'(inflight_o), 32'd4);
    enable_i  = 1'b0;
    dp_budget = -1;
    src1_q    = '{8'hE0, 8'hE1};
    refresh();
    grant_log.delete();
    rcount   = 0;
    last_r   = -1;
    idle_cyc = -1;
    for (int i = 0; i < 30 && idle_cyc < 0; i++) begin
      cycle();
      if (r0_rdy_o || r1_rdy_o) begin
        rcount++;
        if (rcount == 4) last_r = cyc;
      end
      if (idle_o) idle_cyc = cyc;
    end
    check("t4_results", 32'(rcount), 32'd4);
    check("t4_idle_delay", 32'(idle_cyc - last_r), 32'd1);
    check("t4_no_grant", 32'(grant_log.size()), 32'd0);
    enable_i = 1'b1;
    run_quiet(30, done);
    check("t4_resume", 32'(grant_log.size()), 32'd2);

    // Orphan result, then reset with tags in flight
    force_ret = 1'b1;
    cycle();
    check("t5_err", 32'(err_o), 32'd1);
    check("t5_r0_quiet", 32'(r0_rdy_o), 32'd0);
    check("t5_r1_quiet", 32'(r1_rdy_o), 32'd0);
    run(3);
    check("t5_err_sticky", 32'(err_o), 32'd1);
    dp_budget = 0;
    for (int i = 0; i < 5; i++) src1_q.push_back(8'hC8 + 8'(i));
    refresh();
    run(8);
    check("t5_inflight5", 32'(inflight_o), 32'd5);
    pulse_reset();
    check("t5_rst_inflight", 32'(inflight_o), 32'd0);
    check("t5_rst_idle", 32'(idle_o), 32'd1);
    check("t5_rst_err", 32'(err_o), 32'd0);
    check("t5_rst_dp", 32'(dp_rdy_o), 32'd0);
    check("t5_rst_r", 32'({r0_rdy_o, r1_rdy_o}), 32'd0);
    dp_budget = -1;
    src0_q    = '{8'hC0};
    src1_q    = '{8'hD0};
    refresh();
    grant_log.delete();
    run_quiet(20, done);
    check("t5_tie_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) check("t5_tie_s0", 32'(grant_log[0]), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        rate0     = $urandom_range(100);
        rate1     = $urandom_range(100);
        dp_lat    = $urandom_range(5, 1);
        dp_budget = ($urandom_range(3) == 0) ? 0 : -1;
      end
      if ($urandom_range(99) < 4) enable_i = ~enable_i;
      if (src0_q.size() < 2) src0_q.push_back(8'($urandom));
      if (src1_q.size() < 2) src1_q.push_back(8'($urandom));
      reset_i = ($urandom_range(299) == 0);
      cycle();
    end
    reset_i   = 1'b0;
    enable_i  = 1'b1;
    dp_budget = -1;
    rate0     = 100;
    rate1     = 100;
    refresh();
    run_quiet(300, done);
    check("rand_quiet", 32'(done), 32'd1);
    check("rand_err", 32'(err_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
